nbout_writeback_ctrl: RTL

- Controller and storage for NBout on the consumer side of a diannao node.
- Sequences output-neuron groups over multiple input passes.
- Each node result (the node's o_to_edram) is written into a local partial-sum buffer. On the next pass that entry is replayed to the node's i_nbout, with the node's i_load_nbout and i_nbout_nfu2_nfu3 selects driven here.
- After the final (NFU-3) pass, the buffer is drained to eDRAM over a valid/ready interface.

---
 rtl/nbout_writeback_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/nbout_writeback_ctrl.sv
// NBout writeback controller: sequences output groups over input passes, keeps partial sums
// in a local buffer, replays them to the node and drains final results to eDRAM.
module nbout_writeback_ctrl #(
  parameter int unsigned N      = 16,
  parameter int unsigned Tn     = 16,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [ADDR_W:0]     i_num_groups,
  input  logic [7:0]          i_num_passes,
  input  logic [N*Tn-1:0]     i_result,
  input  logic                i_result_valid,
  output logic                o_issue,
  output logic [ADDR_W-1:0]   o_issue_group,
  output logic [N*Tn-1:0]     o_nbout,
  output logic                o_load_nbout,
  output logic                o_nbout_nfu2_nfu3,
  output logic [N*Tn-1:0]     o_wb_data,
  output logic [ADDR_W-1:0]   o_wb_addr,
  output logic                o_wb_valid,
  input  logic                i_wb_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int unsigned W = N * Tn;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StDone} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_g, r_g_last, r_issue_group, r_wb_addr;
  logic [7:0]          r_p, r_p_last;
  logic [W-1:0]        r_nbout, r_wb_data;
  logic                r_issue, r_load, r_nfu23, r_wb_valid, r_busy, r_done, r_err;
  logic [W-1:0]        r_mem [DEPTH];

  logic                w_last_g, w_last_p, w_accept, w_zero_start;
  logic [ADDR_W-1:0]   w_nxt_g;
  logic [7:0]          w_nxt_p;
  logic [W-1:0]        w_replay;
  logic [ADDR_W:0]     w_gc, w_gc_m1;

  assign w_last_g     = (r_g == r_g_last);
  assign w_last_p     = (r_p == r_p_last);
  assign w_accept     = (r_state == StWait) && i_result_valid;
  assign w_nxt_g      = w_last_g ? '0 : r_g + 1'b1;
  assign w_nxt_p      = w_last_g ? r_p + 8'd1 : r_p;
  // With a single group the entry being written is the one replayed next, so forward it.
  assign w_replay     = (w_nxt_g == r_g) ? i_result : r_mem[w_nxt_g];
  assign w_gc         = (i_num_groups > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : i_num_groups;
  assign w_gc_m1      = w_gc - 1'b1;
  assign w_zero_start = (i_num_groups == '0) || (i_num_passes == 8'd0);

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_g] <= i_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_g           <= '0;
      r_g_last      <= '0;
      r_p           <= '0;
      r_p_last      <= '0;
      r_issue       <= 1'b0;
      r_issue_group <= '0;
      r_nbout       <= '0;
      r_load        <= 1'b0;
      r_nfu23       <= 1'b0;
      r_wb_data     <= '0;
      r_wb_addr     <= '0;
      r_wb_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start && w_zero_start) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_busy  <= 1'b1;
          end else if (i_start) begin
            r_g_last      <= w_gc_m1[ADDR_W-1:0];
            r_p_last      <= i_num_passes - 8'd1;
            r_g           <= '0;
            r_p           <= '0;
            r_err         <= 1'b0;
            r_state       <= StIssue;
            r_issue       <= 1'b1;
            r_issue_group <= '0;
            r_nbout       <= '0;
            r_load        <= 1'b1;
            r_nfu23       <= (i_num_passes == 8'd1);
            r_busy        <= 1'b1;
          end
        end
        StIssue: begin
          r_issue <= 1'b0;
          r_state <= StWait;
        end
        StWait: begin
          if (i_result_valid) begin
            if (w_last_g && w_last_p) begin
              r_g     <= '0;
              r_state <= StDrain;
              r_nbout <= '0;
              r_load  <= 1'b0;
              r_nfu23 <= 1'b0;
            end else begin
              r_g           <= w_nxt_g;
              r_p           <= w_nxt_p;
              r_state       <= StIssue;
              r_issue       <= 1'b1;
              r_issue_group <= w_nxt_g;
              r_nbout       <= (w_nxt_p == 8'd0) ? '0 : w_replay;
              r_load        <= 1'b1;
              r_nfu23       <= (w_nxt_p == r_p_last);
            end
          end
        end
        StDrain: begin
          if (!r_wb_valid) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= r_mem[r_g];
            r_wb_addr  <= r_g;
          end else if (i_wb_ready) begin
            r_wb_valid <= 1'b0;
            if (w_last_g) begin
              r_g     <= '0;
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_g <= r_g + 1'b1;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
      if (i_result_valid && (r_state != StWait)) r_err <= 1'b1;
    end
  end

  assign o_issue           = r_issue;
  assign o_issue_group     = r_issue_group;
  assign o_nbout           = r_nbout;
  assign o_load_nbout      = r_load;
  assign o_nbout_nfu2_nfu3 = r_nfu23;
  assign o_wb_data         = r_wb_data;
  assign o_wb_addr         = r_wb_addr;
  assign o_wb_valid        = r_wb_valid;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_err             = r_err;

endmodule
